// File: rtl/vc_fifo_bank_if.sv
// Handshake/status bundle between the source/arbiter and the vc_fifo_bank.
// The master drives push/pop requests. The slave (the bank) returns data and per-channel status.
interface vc_fifo_bank_if #(
  parameter int DATA_W = 5
);
  logic              push;
  logic [1:0]        push_id;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [1:0]        pop_id;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic [3:0]        empty;
  logic [3:0]        full;
  logic [3:0]        almost_full;
  logic              overflow_err;
  logic              underflow_err;

  modport master (
    output push, push_id, data_in, pop, pop_id,
    input  data_out, valid, empty, full, almost_full, overflow_err, underflow_err
  );

  modport slave (
    input  push, push_id, data_in, pop, pop_id,
    output data_out, valid, empty, full, almost_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/vc_fifo_bank.sv
// Four independent virtual-channel FIFOs with a registered pop port and per-channel status flags.
// Define VC_FIFO_ERR_EN to build the registered overflow_err/underflow_err pulses; otherwise both are tied low.
module vc_fifo_bank #(
  parameter int DATA_W    = 5,
  parameter int DEPTH     = 4,
  parameter int AF_THRESH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  vc_fifo_bank_if.slave        bus
);
  localparam int NCH   = 4;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q [NCH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NCH];
  logic [PTR_W-1:0]  wr_ptr_d [NCH];
  logic [PTR_W-1:0]  rd_ptr_q [NCH];
  logic [PTR_W-1:0]  rd_ptr_d [NCH];
  logic [CNT_W-1:0]  cnt_q [NCH];
  logic [CNT_W-1:0]  cnt_d [NCH];
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              valid_q, valid_d;
  logic [NCH-1:0]    empty_s, full_s, af_s;
  logic [NCH-1:0]    push_hit_s, pop_hit_s;
  logic              push_acc_s, pop_acc_s;

  // Status decode from the registered occupancy counters.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      empty_s[i] = (cnt_q[i] == {CNT_W{1'b0}});
      full_s[i]  = (cnt_q[i] == CNT_W'(DEPTH));
      af_s[i]    = (cnt_q[i] >= CNT_W'(AF_THRESH));
    end
  end

  // A push into a full channel still succeeds when the same edge pops that channel.
  always_comb begin
    pop_acc_s  = bus.pop && !empty_s[bus.pop_id];
    push_acc_s = bus.push && (!full_s[bus.push_id] || (pop_acc_s && (bus.pop_id == bus.push_id)));
    for (int i = 0; i < NCH; i++) begin
      push_hit_s[i] = push_acc_s && (bus.push_id == 2'(i));
      pop_hit_s[i]  = pop_acc_s && (bus.pop_id == 2'(i));
    end
  end

  // Per-channel pointer and counter next state.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      if (push_hit_s[i]) begin
        wr_ptr_d[i] = wr_ptr_q[i] + PTR_W'(1);
      end else begin
        wr_ptr_d[i] = wr_ptr_q[i];
      end
      if (pop_hit_s[i]) begin
        rd_ptr_d[i] = rd_ptr_q[i] + PTR_W'(1);
      end else begin
        rd_ptr_d[i] = rd_ptr_q[i];
      end
      case ({push_hit_s[i], pop_hit_s[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
        2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Output register: data_out holds its last word when no pop is accepted.
  always_comb begin
    valid_d = pop_acc_s;
    if (pop_acc_s) begin
      data_out_d = mem_q[bus.pop_id][rd_ptr_q[bus.pop_id]];
    end else begin
      data_out_d = data_out_q;
    end
  end

  // Control state; async reset discards all contents immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= {PTR_W{1'b0}};
        rd_ptr_q[i] <= {PTR_W{1'b0}};
        cnt_q[i]    <= {CNT_W{1'b0}};
      end
      data_out_q <= {DATA_W{1'b0}};
      valid_q    <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
    end
  end

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_acc_s) begin
      mem_q[bus.push_id][wr_ptr_q[bus.push_id]] <= bus.data_in;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.valid       = valid_q;
  assign bus.empty       = empty_s;
  assign bus.full        = full_s;
  assign bus.almost_full = af_s;

`ifdef VC_FIFO_ERR_EN
  logic overflow_err_q, overflow_err_d;
  logic underflow_err_q, underflow_err_d;

  // Rejected-request detection.
  always_comb begin
    overflow_err_d  = bus.push && !push_acc_s;
    underflow_err_d = bus.pop && !pop_acc_s;
  end

  // One-cycle registered error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_err_q  <= 1'b0;
      underflow_err_q <= 1'b0;
    end else begin
      overflow_err_q  <= overflow_err_d;
      underflow_err_q <= underflow_err_d;
    end
  end

  assign bus.overflow_err  = overflow_err_q;
  assign bus.underflow_err = underflow_err_q;
`else
  assign bus.overflow_err  = 1'b0;
  assign bus.underflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_vc_fifo_bank.sv
// Self-checking bench for vc_fifo_bank: directed scenarios followed by random traffic,
// compared against a per-channel queue model.
module tb_vc_fifo_bank;
  localparam int DATA_W    = 5;
  localparam int DEPTH     = 4;
  localparam int AF_THRESH = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vc_fifo_bank_if #(.DATA_W(DATA_W)) bus ();

  vc_fifo_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mq [4][$];
  logic [DATA_W-1:0] exp_dout;
  logic              exp_valid, exp_ovf, exp_unf;
  int                n_checks = 0;
  int                n_errs = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [3:0] e, f, a;
    for (int i = 0; i < 4; i++) begin
      e[i] = (mq[i].size() == 0);
      f[i] = (mq[i].size() == DEPTH);
      a[i] = (mq[i].size() >= AF_THRESH);
    end
    check_val("valid", 32'(bus.valid), 32'(exp_valid));
    check_val("data_out", 32'(bus.data_out), 32'(exp_dout));
    check_val("empty", 32'(bus.empty), 32'(e));
    check_val("full", 32'(bus.full), 32'(f));
    check_val("almost_full", 32'(bus.almost_full), 32'(a));
    check_val("overflow_err", 32'(bus.overflow_err), 32'(exp_ovf));
    check_val("underflow_err", 32'(bus.underflow_err), 32'(exp_unf));
  endtask

  // One clock: apply request, update the model, check after the edge.
  task automatic step(input logic psh, input logic [1:0] pid, input logic [DATA_W-1:0] din,
                      input logic pp, input logic [1:0] qid);
    bit pop_ok, push_ok;
    bus.push    = psh;
    bus.push_id = pid;
    bus.data_in = din;
    bus.pop     = pp;
    bus.pop_id  = qid;
    pop_ok  = pp && (mq[qid].size() != 0);
    push_ok = psh && ((mq[pid].size() < DEPTH) || (pop_ok && (qid == pid)));
    if (pop_ok) exp_dout = mq[qid].pop_front();
    exp_valid = pop_ok;
    if (push_ok) mq[pid].push_back(din);
`ifdef VC_FIFO_ERR_EN
    exp_ovf = psh && !push_ok;
    exp_unf = pp && !pop_ok;
`else
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
`endif
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_push(input logic [1:0] ch, input logic [DATA_W-1:0] d);
    step(1'b1, ch, d, 1'b0, 2'd0);
  endtask

  task automatic do_pop(input logic [1:0] ch);
    step(1'b0, 2'd0, 5'd0, 1'b1, ch);
  endtask

  initial begin
    bus.push = 1'b0; bus.push_id = 2'd0; bus.data_in = 5'd0;
    bus.pop = 1'b0;  bus.pop_id = 2'd0;
    exp_dout = 5'd0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    repeat (2) @(negedge clk);
    check_all();
    reset = 1'b1;
    repeat (3) step(1'b0, 2'd0, 5'd0, 1'b0, 2'd0);

    // In-order delivery on channel 2, back-to-back pops.
    do_push(2'd2, 5'h01); do_push(2'd2, 5'h02); do_push(2'd2, 5'h03);
    do_pop(2'd2); do_pop(2'd2); do_pop(2'd2);

    // Overfill channel 0, then drain plus one pop past empty.
    for (int k = 0; k < 5; k++) do_push(2'd0, 5'(5'h10 + k));
    for (int k = 0; k < 5; k++) do_pop(2'd0);

    // Full channel 1: simultaneous push and pop.
    for (int k = 0; k < 4; k++) do_push(2'd1, 5'(5'h04 + k));
    step(1'b1, 2'd1, 5'h1F, 1'b1, 2'd1);
    for (int k = 0; k < 4; k++) do_pop(2'd1);

    // Empty channel 3: pop rejected, push accepted.
    step(1'b1, 2'd3, 5'h0A, 1'b1, 2'd3);
    do_pop(2'd3);

    // Mid-stream asynchronous reset.
    for (int c = 0; c < 4; c++) begin
      do_push(2'(c), 5'(5'h11 + 2 * c));
      do_push(2'(c), 5'(5'h12 + 2 * c));
    end
    do_pop(2'd0);
    bus.pop = 1'b0;
    reset = 1'b0;
    #1;
    for (int c = 0; c < 4; c++) mq[c].delete();
    exp_dout = 5'd0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    check_all();
    reset = 1'b1;
    do_pop(2'd0);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom),
           1'($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/vc_fifo_bank.md
# vc_fifo_bank

Four-channel input FIFO bank feeding the round-robin arbitration stage. Holds one independent FIFO per virtual channel, accepts one pushed word per cycle on a selected channel, and returns a popped word one cycle after the arbiter's pop request. Presents per-channel `empty`, `full` and `almost_full` status so the arbiter skips empty channels and the source throttles before overflow.

## Interface

Parameters:
- `DATA_W`, 5: word width per channel.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `AF_THRESH`, 3: `almost_full[i]` asserts when occupancy ≥ this; 1 ≤ value ≤ `DEPTH`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  write strobe.
- `push_id`  in  2  target channel for `push`.
- `data_in`  in  `DATA_W`  word to write.
- `pop`  in  1  read strobe from the arbiter.
- `pop_id`  in  2  source channel for `pop`.
- `data_out`  out  `DATA_W`  popped word, registered.
- `valid`  out  1  `data_out` holds a word popped on the previous edge.
- `empty`  out  4  per-channel occupancy == 0.
- `full`  out  4  per-channel occupancy == `DEPTH`.
- `almost_full`  out  4  per-channel occupancy ≥ `AF_THRESH`.
- `overflow_err`  out  1  one-cycle pulse: push to a full channel was dropped (see Configuration).
- `underflow_err`  out  1  one-cycle pulse: pop from an empty channel was ignored (see Configuration).

## Operation

- Storage: 4 × `DEPTH` × `DATA_W`; per channel a write pointer, a read pointer, and an occupancy counter of width log2(`DEPTH`)+1.
- Pointers wrap modulo `DEPTH` with no gap; the counter never wraps.
- Push accepted when `push`=1 and channel `push_id` is not full at the edge: word written at wr_ptr, wr_ptr+1, count+1.
- Pop accepted when `pop`=1 and channel `pop_id` is not empty at the edge: `data_out` ← mem[rd_ptr], rd_ptr+1, count−1, `valid`←1.
- Any edge without an accepted pop: `valid`←0; `data_out` holds its last value.
- Same channel, push and pop on the same edge:
  - Neither empty nor full: both accepted, count unchanged.
  - Full: pop accepted; push accepted into the freed slot; count stays `DEPTH`; no overflow.
  - Empty: push accepted; pop rejected (no bypass); underflow pulses; `valid`=0.
- Different channels, push and pop on the same edge: both evaluated independently.
- Rejected push: no state change; `overflow_err`=1 for that cycle.
- Rejected pop: no state change; `underflow_err`=1 for that cycle.
- Status flags decode combinationally from the registered counters, so they reflect the last edge only.

## Timing

- Reset (async assert, sync deassert by source): all counters and pointers 0, `empty`=4'b1111, `full`=0, `almost_full`=0, `data_out`=0, `valid`=0, both error outputs 0. Memory contents are not reset.
- Reset asserted mid-operation: all contents are discarded immediately; `valid` drops without waiting for a clock.
- Push latency: `empty[i]` falls in the cycle after the accepting edge. The word is poppable on the next edge.
- Pop latency: word on `data_out` with `valid`=1 in the cycle after the edge that sampled `pop`. Back-to-back pops give one word per cycle.
- Error pulses are registered and last exactly one cycle per rejected request.
- The arbiter must sample `empty` before issuing `pop`; the bank tolerates violations via the rules above.

## Configuration

- `VC_FIFO_ERR_EN` defined: overflow/underflow detection and the registered `overflow_err`/`underflow_err` pulses are built.
- Not defined: the detection logic is omitted and both outputs are tied to 0. Rejection behaviour (drop push / ignore pop) is identical in both builds.

## Test plan

- Reset, then idle 3 cycles -> `empty`=4'b1111, `full`=0, `valid`=0, `data_out`=0.
- Push 5'h01, 5'h02, 5'h03 to channel 2; pop channel 2 three times back-to-back -> `data_out` 01, 02, 03 on consecutive cycles with `valid`=1; `empty[2]` returns to 1 after the last pop.
- Push 5 words to channel 0 (`DEPTH`=4) -> `almost_full[0]` rises after the 3rd push, `full[0]` after the 4th; 5th word dropped with one `overflow_err` pulse (macro on); pops return only the first 4 words.
- With channel 1 full, push 5'h1F and pop channel 1 on the same edge -> oldest word output, `full[1]` stays 1, no error; 5'h1F is returned as the 4th subsequent pop.
- Pop empty channel 3 while pushing 5'h0A to it -> `valid`=0, `underflow_err` pulses once; the next pop of channel 3 returns 5'h0A.
- Fill channels 0–3 with 2 words each, assert `reset` mid-stream for 1 ns without a clock edge -> all outputs at reset values immediately; first pop after release is rejected.
